// File: rtl/svc_fb_rd_arb_if.sv
// One AXI read port (AR + R channels). The master modport issues reads and
// the slave modport answers them.
interface svc_fb_rd_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int ID_W   = 4
) ();
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/svc_fb_rd_arb.sv
// Two-requester round-robin AXI read arbiter sharing one frame buffer read
// port. Read data is steered back by the top bit of the master read ID.
module svc_fb_rd_arb #(
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic            clk,
  input  logic            rst,
  svc_fb_rd_arb_if.slave  s0_axi,
  svc_fb_rd_arb_if.slave  s1_axi,
  svc_fb_rd_arb_if.master m_axi
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic                      arvalid_p1;
  logic [AXI_ID_WIDTH:0]     arid_p1;
  logic [AXI_ADDR_WIDTH-1:0] araddr_p1;
  logic [7:0]                arlen_p1;
  logic [2:0]                arsize_p1;
  logic [1:0]                arburst_p1;
  logic                      last_grant;
  logic [CNT_W-1:0]          outstanding;

  logic                      slot_free;
  logic                      eligible;
  logic                      gnt0;
  logic                      gnt1;
  logic                      grant;
  logic                      burst_done;
  logic                      sel;
  logic [AXI_DATA_WIDTH-1:0] rdata;

  // A stray rlast with nothing outstanding must not wrap the counter.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + 1'b1;
    else if (dec && !inc && (cnt != '0))
      res = cnt - 1'b1;
    return res;
  endfunction

  assign slot_free  = !arvalid_p1 || m_axi.arready;
  assign eligible   = slot_free && (outstanding < MAX_CNT);
  assign gnt0       = eligible && s0_axi.arvalid && (!s1_axi.arvalid || last_grant);
  assign gnt1       = eligible && s1_axi.arvalid && (!s0_axi.arvalid || !last_grant);
  assign grant      = gnt0 || gnt1;
  assign burst_done = m_axi.rvalid && m_axi.rready && m_axi.rlast;

  assign s0_axi.arready = gnt0;
  assign s1_axi.arready = gnt1;

  // Stage p1: registered master AR channel, loaded only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_p1  <= 1'b0;
      arid_p1     <= '0;
      araddr_p1   <= '0;
      arlen_p1    <= '0;
      arsize_p1   <= '0;
      arburst_p1  <= '0;
      last_grant  <= 1'b1;
      outstanding <= '0;
    end else begin
      if (grant) begin
        arvalid_p1 <= 1'b1;
        last_grant <= gnt1;
        if (gnt1) begin
          arid_p1    <= {1'b1, s1_axi.arid};
          araddr_p1  <= s1_axi.araddr;
          arlen_p1   <= s1_axi.arlen;
          arsize_p1  <= s1_axi.arsize;
          arburst_p1 <= s1_axi.arburst;
        end else begin
          arid_p1    <= {1'b0, s0_axi.arid};
          araddr_p1  <= s0_axi.araddr;
          arlen_p1   <= s0_axi.arlen;
          arsize_p1  <= s0_axi.arsize;
          arburst_p1 <= s0_axi.arburst;
        end
      end else if (m_axi.arready) begin
        arvalid_p1 <= 1'b0;
      end
      outstanding <= next_count(outstanding, grant, burst_done);
    end
  end

  assign m_axi.arvalid = arvalid_p1;
  assign m_axi.arid    = arid_p1;
  assign m_axi.araddr  = araddr_p1;
  assign m_axi.arlen   = arlen_p1;
  assign m_axi.arsize  = arsize_p1;
  assign m_axi.arburst = arburst_p1;

  // R channel is a pure combinational steer; payload goes to both sides.
  assign sel          = m_axi.rid[AXI_ID_WIDTH];
  assign rdata        = m_axi.rdata;
  assign m_axi.rready = sel ? s1_axi.rready : s0_axi.rready;

  assign s0_axi.rvalid = m_axi.rvalid && !sel;
  assign s0_axi.rid    = m_axi.rid[AXI_ID_WIDTH-1:0];
  assign s0_axi.rdata  = rdata;
  assign s0_axi.rresp  = m_axi.rresp;
  assign s0_axi.rlast  = m_axi.rlast;

  assign s1_axi.rvalid = m_axi.rvalid && sel;
  assign s1_axi.rid    = m_axi.rid[AXI_ID_WIDTH-1:0];
  assign s1_axi.rdata  = rdata;
  assign s1_axi.rresp  = m_axi.rresp;
  assign s1_axi.rlast  = m_axi.rlast;
endmodule
